// File: rtl/lut_ram_mp_pkg.sv
// Shared types and helpers for the multi-read-port LUT RAM.
package lut_ram_mp_pkg;

    localparam int unsigned MAX_W  = 128;
    localparam int unsigned MAX_NB = MAX_W / 8;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } clr_state_t;

    function automatic int unsigned num_bytes(input int unsigned width);
        return width / 8;
    endfunction

    // Words narrower than MAX_W are zero-extended by the caller and truncated back.
    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]  old_w,
                                                     input logic [MAX_W-1:0]  new_w,
                                                     input logic [MAX_NB-1:0] be);
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(MAX_NB); i++) begin
            if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lut_ram_mp_if.sv
// Write, read and clear-control bundle of the multi-read-port LUT RAM.
interface lut_ram_mp_if #(
    parameter int unsigned LUT_WIDTH = 32,
    parameter int unsigned LUT_DEPTH = 256,
    parameter int unsigned NUM_RD    = 2
);
    localparam int unsigned AW = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam int unsigned NB = lut_ram_mp_pkg::num_bytes(LUT_WIDTH);

    logic                                wr_en;
    logic [AW-1:0]                       wr_addr;
    logic [NB-1:0]                       wr_be;
    logic [LUT_WIDTH-1:0]                wr_data;
    logic [NUM_RD-1:0][AW-1:0]           rd_addr;
    logic [NUM_RD-1:0][LUT_WIDTH-1:0]    rd_data;
    logic                                init_req;
    logic                                busy;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_addr, init_req,
        input  rd_data, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_addr, init_req,
        output rd_data, busy
    );

endinterface

// File: rtl/lut_ram_mp_clr_seq.sv
// Clear sequencer: sweeps every address once after reset and on init_req.
module lut_ram_mp_clr_seq
    import lut_ram_mp_pkg::*;
#(
    parameter int unsigned LUT_DEPTH = 256,
    parameter int unsigned AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_req_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          busy_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(LUT_DEPTH - 1);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // init_req is only sampled in S_READY, so a mid-sweep request cannot restart it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            S_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            S_READY: begin
                if (init_req_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    assign clr_we_o   = busy_q;
    assign clr_addr_o = cnt_q;
    assign busy_o     = busy_q;

endmodule

// File: rtl/lut_ram_mp.sv
// Multi-read-port LUT RAM with byte-enable writes, optional registered reads and clear sweep.
module lut_ram_mp
    import lut_ram_mp_pkg::*;
#(
    parameter int unsigned          LUT_WIDTH  = 32,
    parameter int unsigned          LUT_DEPTH  = 256,
    parameter int unsigned          NUM_RD     = 2,
    parameter int unsigned          RD_REG     = 0,
    parameter logic [LUT_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    lut_ram_mp_if.slave  mem_if
);

    localparam int unsigned AW  = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1;
    localparam int unsigned AWP = AW + 1;

    logic [LUT_WIDTH-1:0]             mem [LUT_DEPTH];
    logic                             clr_we;
    logic [AW-1:0]                    clr_addr;
    logic                             busy;
    logic                             wr_ok_c;
    logic [LUT_WIDTH-1:0]             wr_merged_c;
    logic [NUM_RD-1:0][LUT_WIDTH-1:0] rd_word_c;

    function automatic logic in_range(input logic [AW-1:0] a);
        return AWP'(a) < AWP'(LUT_DEPTH);
    endfunction

    lut_ram_mp_clr_seq #(
        .LUT_DEPTH (LUT_DEPTH),
        .AW        (AW)
    ) u_clr_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_req_i (mem_if.init_req),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .busy_o     (busy)
    );

    assign mem_if.busy = busy;

    // User write qualification and byte merge against the stored word.
    always_comb begin
        wr_ok_c     = mem_if.wr_en && !busy && in_range(mem_if.wr_addr);
        wr_merged_c = LUT_WIDTH'(byte_merge(MAX_W'(mem[mem_if.wr_addr]),
                                            MAX_W'(mem_if.wr_data),
                                            MAX_NB'(mem_if.wr_be)));
    end

    // Array write port; the clear sweep owns the port while it runs.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VALUE;
        end else if (wr_ok_c) begin
            mem[mem_if.wr_addr] <= wr_merged_c;
        end
    end

    // Per-port read word; the write-first bypass only matters on the registered path.
    always_comb begin
        for (int p = 0; p < int'(NUM_RD); p++) begin
            rd_word_c[p] = '0;
            if (!busy && in_range(mem_if.rd_addr[p])) begin
                if ((RD_REG != 0) && wr_ok_c && (mem_if.wr_addr == mem_if.rd_addr[p])) begin
                    rd_word_c[p] = wr_merged_c;
                end else begin
                    rd_word_c[p] = mem[mem_if.rd_addr[p]];
                end
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [NUM_RD-1:0][LUT_WIDTH-1:0] rd_data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_word_c;
                end
            end

            assign mem_if.rd_data = rd_data_q;
        end else begin : g_rd_comb
            assign mem_if.rd_data = rd_word_c;
        end
    endgenerate

endmodule

// File: tb/tb_lut_ram_mp.sv
// Directed bench: combinational-read RAM (depth 256) and registered-read RAM (depth 200) side by side.
module tb_lut_ram_mp;

    localparam int unsigned W      = 32;
    localparam int unsigned DA     = 256;
    localparam int unsigned DB     = 200;
    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'hA5A5_0F0F;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    lut_ram_mp_if #(.LUT_WIDTH(W), .LUT_DEPTH(DA), .NUM_RD(2)) bus_a ();
    lut_ram_mp_if #(.LUT_WIDTH(W), .LUT_DEPTH(DB), .NUM_RD(2)) bus_b ();

    lut_ram_mp #(
        .LUT_WIDTH(W), .LUT_DEPTH(DA), .NUM_RD(2), .RD_REG(0), .INIT_VALUE(INIT_A)
    ) u_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_if (bus_a)
    );

    lut_ram_mp #(
        .LUT_WIDTH(W), .LUT_DEPTH(DB), .NUM_RD(2), .RD_REG(1), .INIT_VALUE(INIT_B)
    ) u_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_if (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_all();
        bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_be = '0; bus_a.wr_data = '0;
        bus_a.rd_addr = '0; bus_a.init_req = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_be = '0; bus_b.wr_data = '0;
        bus_b.rd_addr = '0; bus_b.init_req = 1'b0;
    endtask

    task automatic wr_a(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = addr; bus_a.wr_data = data; bus_a.wr_be = be;
        @(posedge clk); #1;
        bus_a.wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = addr; bus_b.wr_data = data; bus_b.wr_be = be;
        @(posedge clk); #1;
        bus_b.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int fall_a;
        int fall_b;
        rst_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus_a.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy_a got %b exp 1", bus_a.busy); end
        n_cmp++; if (bus_b.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy_b got %b exp 1", bus_b.busy); end
        n_cmp++; if (bus_b.rd_data !== 64'h0) begin n_err++; $display("FAIL rst_rdreg_b got %h exp 0", bus_b.rd_data); end
        rst_n = 1'b1;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 8'd3; bus_a.wr_data = 32'hDEAD_BEEF; bus_a.wr_be = 4'hF;
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 8'd3; bus_b.wr_data = 32'hDEAD_BEEF; bus_b.wr_be = 4'hF;
        bus_a.rd_addr[0] = 8'd3;
        bus_b.rd_addr[0] = 8'd3;
        fall_a = -1;
        fall_b = -1;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk); #1;
            if (e == 4) begin
                bus_a.wr_en = 1'b0;
                bus_b.wr_en = 1'b0;
            end
            if (e == 2) begin
                n_cmp++; if (bus_a.rd_data[0] !== 32'h0) begin n_err++; $display("FAIL sweep_mask_a got %h exp 0", bus_a.rd_data[0]); end
                n_cmp++; if (bus_b.rd_data[0] !== 32'h0) begin n_err++; $display("FAIL sweep_mask_b got %h exp 0", bus_b.rd_data[0]); end
            end
            if (fall_a < 0 && bus_a.busy === 1'b0) fall_a = e;
            if (fall_b < 0 && bus_b.busy === 1'b0) fall_b = e;
        end
        n_cmp++; if (fall_a != 256) begin n_err++; $display("FAIL sweep_len_a got %0d exp 256", fall_a); end
        n_cmp++; if (fall_b != 200) begin n_err++; $display("FAIL sweep_len_b got %0d exp 200", fall_b); end
        for (int a = 0; a < 256; a++) begin
            bus_a.rd_addr[0] = 8'(a);
            bus_a.rd_addr[1] = 8'(255 - a);
            #1;
            n_cmp++; if (bus_a.rd_data[0] !== INIT_A) begin n_err++; $display("FAIL clear_a p0 addr %0d got %h exp %h", a, bus_a.rd_data[0], INIT_A); end
            n_cmp++; if (bus_a.rd_data[1] !== INIT_A) begin n_err++; $display("FAIL clear_a p1 addr %0d got %h exp %h", 255 - a, bus_a.rd_data[1], INIT_A); end
        end
        bus_b.rd_addr[0] = 8'd3;
        bus_b.rd_addr[1] = 8'd199;
        @(posedge clk); #1;
        n_cmp++; if (bus_b.rd_data[0] !== INIT_B) begin n_err++; $display("FAIL clear_b addr3 got %h exp %h", bus_b.rd_data[0], INIT_B); end
        n_cmp++; if (bus_b.rd_data[1] !== INIT_B) begin n_err++; $display("FAIL clear_b addr199 got %h exp %h", bus_b.rd_data[1], INIT_B); end
    endtask

    task automatic test_byte_enable();
        wr_a(8'd5, 32'hAABB_CCDD, 4'b1111);
        wr_a(8'd5, 32'h1122_3344, 4'b0101);
        bus_a.rd_addr[0] = 8'd5;
        bus_a.rd_addr[1] = 8'd5;
        #1;
        n_cmp++; if (bus_a.rd_data[0] !== 32'hAA22_CC44) begin n_err++; $display("FAIL be_merge got %h exp aa22cc44", bus_a.rd_data[0]); end
        n_cmp++; if (bus_a.rd_data[1] !== 32'hAA22_CC44) begin n_err++; $display("FAIL be_same_addr_p1 got %h exp aa22cc44", bus_a.rd_data[1]); end
        wr_a(8'd5, 32'hFFFF_FFFF, 4'b0000);
        #1;
        n_cmp++; if (bus_a.rd_data[0] !== 32'hAA22_CC44) begin n_err++; $display("FAIL be_zero got %h exp aa22cc44", bus_a.rd_data[0]); end
    endtask

    task automatic test_read_old();
        wr_a(8'd7, 32'h0000_0001, 4'hF);
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 8'd7; bus_a.wr_data = 32'h0000_0002; bus_a.wr_be = 4'hF;
        bus_a.rd_addr[0] = 8'd7;
        #1;
        n_cmp++; if (bus_a.rd_data[0] !== 32'h1) begin n_err++; $display("FAIL read_old_before got %h exp 1", bus_a.rd_data[0]); end
        @(posedge clk); #1;
        bus_a.wr_en = 1'b0;
        n_cmp++; if (bus_a.rd_data[0] !== 32'h2) begin n_err++; $display("FAIL read_old_after got %h exp 2", bus_a.rd_data[0]); end
    endtask

    task automatic test_bypass();
        wr_b(8'd9, 32'hFFFF_0000, 4'hF);
        bus_b.wr_en = 1'b1; bus_b.wr_addr = 8'd9; bus_b.wr_data = 32'h0000_ABCD; bus_b.wr_be = 4'b0011;
        bus_b.rd_addr[0] = 8'd9;
        bus_b.rd_addr[1] = 8'd9;
        @(posedge clk); #1;
        bus_b.wr_en = 1'b0;
        n_cmp++; if (bus_b.rd_data[0] !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL bypass_p0 got %h exp ffffabcd", bus_b.rd_data[0]); end
        n_cmp++; if (bus_b.rd_data[1] !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL bypass_p1 got %h exp ffffabcd", bus_b.rd_data[1]); end
        @(posedge clk); #1;
        n_cmp++; if (bus_b.rd_data[0] !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL bypass_stored got %h exp ffffabcd", bus_b.rd_data[0]); end
    endtask

    task automatic test_range();
        wr_b(8'd210, 32'h1234_5678, 4'hF);
        wr_b(8'd199, 32'hCAFE_BABE, 4'hF);
        bus_b.rd_addr[0] = 8'd210;
        bus_b.rd_addr[1] = 8'd199;
        @(posedge clk); #1;
        n_cmp++; if (bus_b.rd_data[0] !== 32'h0) begin n_err++; $display("FAIL range_rd210 got %h exp 0", bus_b.rd_data[0]); end
        n_cmp++; if (bus_b.rd_data[1] !== 32'hCAFE_BABE) begin n_err++; $display("FAIL range_rd199 got %h exp cafebabe", bus_b.rd_data[1]); end
        bus_b.rd_addr[0] = 8'd10;
        bus_b.rd_addr[1] = 8'd9;
        @(posedge clk); #1;
        n_cmp++; if (bus_b.rd_data[0] !== INIT_B) begin n_err++; $display("FAIL range_alias10 got %h exp %h", bus_b.rd_data[0], INIT_B); end
        n_cmp++; if (bus_b.rd_data[1] !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL indep_p1 got %h exp ffffabcd", bus_b.rd_data[1]); end
    endtask

    task automatic test_init_req();
        int n;
        for (int i = 0; i < 4; i++) wr_a(8'(i), 32'h1234_5678, 4'hF);
        bus_a.rd_addr[0] = 8'd2;
        #1;
        n_cmp++; if (bus_a.rd_data[0] !== 32'h1234_5678) begin n_err++; $display("FAIL init_fill got %h exp 12345678", bus_a.rd_data[0]); end
        bus_a.init_req = 1'b1;
        @(posedge clk); #1;
        bus_a.init_req = 1'b0;
        n = 0;
        while (bus_a.busy === 1'b1 && n < 600) begin
            n++;
            if (n == 10) begin
                n_cmp++; if (bus_a.rd_data[0] !== 32'h0) begin n_err++; $display("FAIL init_mask got %h exp 0", bus_a.rd_data[0]); end
            end
            if (n == 100) bus_a.init_req = 1'b1;
            if (n == 101) bus_a.init_req = 1'b0;
            @(posedge clk); #1;
        end
        bus_a.init_req = 1'b0;
        n_cmp++; if (n != 256) begin n_err++; $display("FAIL init_busy_len got %0d exp 256", n); end
        for (int i = 0; i < 4; i++) begin
            bus_a.rd_addr[0] = 8'(i);
            #1;
            n_cmp++; if (bus_a.rd_data[0] !== INIT_A) begin n_err++; $display("FAIL init_cleared addr %0d got %h exp %h", i, bus_a.rd_data[0], INIT_A); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        wr_b(8'd20, 32'h1111_1111, 4'hF);
        bus_b.rd_addr[0] = 8'd20;
        @(posedge clk); #1;
        n_cmp++; if (bus_b.rd_data[0] !== 32'h1111_1111) begin n_err++; $display("FAIL rstmid_fill got %h exp 11111111", bus_b.rd_data[0]); end
        bus_b.init_req = 1'b1;
        @(posedge clk); #1;
        bus_b.init_req = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_b.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got %b exp 1", bus_b.busy); end
        n_cmp++; if (bus_b.rd_data[0] !== 32'h0) begin n_err++; $display("FAIL rstmid_rdreg got %h exp 0", bus_b.rd_data[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (bus_b.busy === 1'b1 && n < 600) begin
            n++;
            @(posedge clk); #1;
        end
        n_cmp++; if (n != 200) begin n_err++; $display("FAIL rstmid_len got %0d exp 200", n); end
        @(posedge clk); #1;
        n_cmp++; if (bus_b.rd_data[0] !== INIT_B) begin n_err++; $display("FAIL rstmid_cleared got %h exp %h", bus_b.rd_data[0], INIT_B); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_all();
        test_reset();
        test_byte_enable();
        test_read_old();
        test_bypass();
        test_range();
        test_init_req();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lut_ram_mp.md
Name: lut_ram_mp

Overview:
Parametrised multi-read-port LUT RAM. It is the successor to the single-port lut_ram.
- Adds byte-enable writes, N independent read ports and a selectable combinational or registered read path.
- Adds a hardware clear sequencer, which initialises the array after reset and on request.
- Used as a general storage primitive: register-file variants, small data memories and scratch tables in the riscv_32i core.

Parameters:
- LUT_WIDTH, 32 (XLEN): data width in bits; must be a multiple of 8.
- LUT_DEPTH, 256: number of words; need not be a power of two.
- NUM_RD, 2: number of independent read ports, 1..4.
- RD_REG, 0: 0 = combinational read; 1 = registered read with 1-cycle latency.
- INIT_VALUE, 0: LUT_WIDTH-bit word written to every location by the clear sequencer.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  AW=$clog2(LUT_DEPTH)  write address.
- wr_be  in  LUT_WIDTH/8  byte enables; bit i covers byte i.
- wr_data  in  LUT_WIDTH  write data.
- rd_addr  in  NUM_RD x AW  read addresses, one per port.
- rd_data  out  NUM_RD x LUT_WIDTH  read data, one per port.
- init_req  in  1  pulse; starts a full clear sweep.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = S_CLEAR, clr_cnt = 0, busy = 1.
  - RD_REG=1: all rd_data registers = 0.
  - Array contents are not reset asynchronously; the sweep initialises them.
- FSM, two states:
  - S_CLEAR: each cycle writes mem[clr_cnt] = INIT_VALUE, then clr_cnt++. When clr_cnt == LUT_DEPTH-1 is written, go to S_READY and clear clr_cnt. A sweep takes exactly LUT_DEPTH cycles from reset release or from the init_req edge.
  - S_READY: busy = 0. init_req=1 at a clock edge -> S_CLEAR with clr_cnt = 0, and busy goes high the following cycle.
  - init_req while in S_CLEAR is ignored; it does not restart the sweep.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- User writes:
  - Accepted at posedge only when wr_en && !busy. Only the bytes with wr_be[i]=1 are updated; the other bytes keep their value.
  - wr_be = 0 is a no-op.
  - Writes while busy are dropped and are not queued.
  - wr_addr >= LUT_DEPTH: the write is ignored.
- Reads, RD_REG=0:
  - rd_data[p] = mem[rd_addr[p]] combinationally.
  - A same-cycle write is not visible until after the edge (read-old).
- Reads, RD_REG=1:
  - rd_data[p] is registered at posedge; latency 1.
  - Write-first bypass: if the same edge writes to rd_addr[p], rd_data[p] holds the byte-merged new word.
- Read masking, both modes:
  - rd_addr[p] >= LUT_DEPTH -> rd_data[p] = 0.
  - While busy, rd_data[p] = 0. For RD_REG=1 this applies to the value captured at each edge where busy=1.
- Multiple read ports:
  - Ports are fully independent.
  - Several ports may read the same address and must return identical data.

Decomposition:
- Package lut_ram_mp_pkg:
  - typedef enum {S_CLEAR, S_READY} clr_state_t.
  - Function for the byte-merge (old word, new word, be).
  - Localparam helper NUM_BYTES(width).
- Sub-module lut_ram_mp_clr_seq: owns the FSM, clr_cnt and busy. It outputs clr_we, clr_addr and busy into the array write mux.
- Top level: array, write mux (clear sweep has priority over user writes), read ports and the optional output registers.
- Bench: extend the lut_ram reference model with a byte-enable update and a clear(); the transaction gains wr_be and a rd_addr/rd_data array.

Test Plan:
- Reset release, LUT_DEPTH=256, INIT_VALUE=0: busy stays 1 for exactly 256 cycles then drops. Every read of addresses 0..255 returns 0x0. A write issued during the sweep leaves the target at 0.
- Byte enables: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101. Addr 5 reads 0xAA22CC44; be=0 leaves it unchanged.
- RD_REG=0, same-cycle read-old: addr 7 = 0x1; in one cycle write 0x2 to addr 7 while port0 reads addr 7 -> 0x1 before the edge, 0x2 after it.
- RD_REG=1 bypass: addr 9 = 0xFFFF0000; write 0x0000ABCD with be=4'b0011 and read addr 9 on both ports the same edge. Both ports show 0xFFFFABCD one cycle later.
- init_req mid-operation:
  - Fill addrs 0..3 with 0x12345678, pulse init_req -> busy for LUT_DEPTH cycles, reads forced 0, then all addrs = INIT_VALUE.
  - A second init_req mid-sweep does not extend busy.
  - rst_n low mid-sweep restarts the full count.
- Range, LUT_DEPTH=200: write to addr 210 is ignored; reads of addr 210 return 0; addr 199 writes and reads back normally.
